// File: rtl/md_sequencer.sv
// md_sequencer: multicycle multiply/divide unit for the MIPS pipeline.
// Owns architectural HI/LO. mult/div results are computed when a request is
// accepted and held in res_hi/res_lo. They are committed to HI/LO after a fixed
// busy latency. mthi/mtlo write HI/LO directly on the next edge.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_req_id,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic               divz_q, divz_d;
  logic               done_q, done_d;
  logic               accept;

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] mul_u(input logic [31:0] x, input logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Signed 32x32 -> 64 product; the low 64 bits of the sign-extended product are exact.
  function automatic logic [63:0] mul_s(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] xs, ys;
    xs = $signed({{32{x[31]}}, x});
    ys = $signed({{32{y[31]}}, y});
    return 64'(xs * ys);
  endfunction

  // Unsigned divide returning {remainder, quotient}; zero divisor yields 0 (result is discarded).
  function automatic logic [63:0] div_u(input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return 64'd0;
    return {x % y, x / y};
  endfunction

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 rem 0.
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  function automatic logic [63:0] div_s(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mx, my, q, r;
    mx = x[31] ? (32'd0 - x) : x;
    my = y[31] ? (32'd0 - y) : y;
    if (my == 32'd0) return 64'd0;
    q = mx / my;
    r = mx % my;
    if (x[31] ^ y[31]) q = 32'd0 - q;
    if (x[31])         r = 32'd0 - r;
    return {r, q};
  endfunction

  assign accept   = start & ~cancel & (state_q == IDLE);
  assign busy     = (state_q == RUN);
  assign md_stall = md_req_id & (busy | (start & ~cancel & (md_op <= 3'd3)));
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;

  // Next-state logic: accept requests in IDLE, count down and commit in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    divz_d   = divz_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (md_op)
            3'b000: begin
              {res_hi_d, res_lo_d} = mul_s(a, b);
              divz_d  = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            3'b001: begin
              {res_hi_d, res_lo_d} = mul_u(a, b);
              divz_d  = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            3'b010: begin
              {res_hi_d, res_lo_d} = div_s(a, b);
              divz_d  = (b == 32'd0);
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            3'b011: begin
              {res_hi_d, res_lo_d} = div_u(a, b);
              divz_d  = (b == 32'd0);
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            3'b100:  hi_d = a;
            3'b101:  lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Start requests here are ignored; the upstream stall should prevent them.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          if (!divz_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, HI/LO and pending-result registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      divz_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      divz_q   <= divz_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multicycle multiply/divide sequencer for the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo requests from the EX stage and runs each operation for a fixed latency. It owns the architectural HI/LO registers and drives the busy and stall signals that the hazard controller uses to hold MD-class instructions in ID. An exception flush masks a request issued in the same cycle.

## Interface

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10: busy cycles for div/divu (≥1)

Ports:
- clk  input  1  — single clock, rising edge
- reset  input  1  — one clock; reset is asynchronous and active-low (0 = reset asserted)
- start  input  1  — EX-stage request valid (one cycle per instruction)
- md_op  input  3  — 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 no-op
- cancel  input  1  — exception flush; masks start in the same cycle
- a  input  32  — rs operand (forwarded)
- b  input  32  — rt operand (forwarded)
- md_req_id  input  1  — ID stage holds an MD-class instruction (mult…mflo, mthi, mtlo)
- busy  output  1  — operation in progress
- md_stall  output  1  — combinational: md_req_id & (busy | (start & ~cancel & md_op<=011))
- hi  output  32  — architectural HI
- lo  output  32  — architectural LO
- done  output  1  — one-cycle pulse when HI/LO take a mult/div result

## Operation

- States: IDLE, RUN. Down-counter cnt, width sufficient for max(MULT_CYCLES, DIV_CYCLES).
- Accepted request = start & ~cancel & state==IDLE.
- IDLE, accepted md_op 000–011: compute 64-bit result into pending registers (res_hi/res_lo), load cnt with the op latency N, go to RUN.
- RUN: each cycle cnt decrements. When cnt reaches 1 → next edge: hi<=res_hi, lo<=res_lo, done<=1, state<=IDLE.
- IDLE, accepted md_op 100: hi<=a at next edge. md_op 101: lo<=a. done stays 0, busy stays 0.
- md_op 110/111: ignored.
- start while RUN: ignored. The upstream stall makes this illegal; RTL must still not corrupt state.
- cancel has no effect on an operation already in RUN. The instruction is past EX and commits.
- Arithmetic:
  - mult: signed 32×32→64, {hi,lo}.
  - multu: unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned.
  - 0x80000000 div 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: the operation still runs DIV_CYCLES busy cycles; hi/lo are left unchanged; done still pulses.
- Reset (asynchronous, any state): state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0. Any pending result is discarded.

## Timing

- Request sampled at edge k (end of EX cycle). busy is high in cycles k+1 … k+N, exactly N cycles.
- New hi/lo and done=1 are visible in cycle k+N+1. busy=0 in that cycle.
- mfhi/mflo issued in cycle k+N+1 reads the new value; no bypass exists from res_*.
- mthi/mtlo sampled at edge k are visible in cycle k+1; busy never rises for them.
- md_stall rises in cycle k if md_req_id=1 together with an accepted mult/div start. It stays high through cycle k+N and is low in cycle k+N+1.
- Back-to-back: a start accepted in cycle k+N+1 is legal. The next busy window begins at k+N+2.
- Reset asserted mid-RUN: outputs clear immediately (asynchronous). The first accepted start after release behaves as from IDLE.

## Test plan

- mult a=0xFFFFFFFD (−3), b=5 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, with done pulsing for 1 cycle.
- multu a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE. Then div a=0xFFFFFFF9 (−7), b=2 → 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles → hi and lo update one cycle after each; busy and done stay 0. Follow with divu b=0 → 10 busy cycles, hi/lo unchanged, done pulses.
- start=1 with md_op=000 and cancel=1 → no busy, hi/lo unchanged. Then start during RUN with a different op → ignored, and the original result lands.
- md_req_id=1 held while a div issues → md_stall high from the issue cycle through the last busy cycle, low the cycle hi/lo update.
- reset pulled low at busy cycle 3 of a mult → hi=lo=0, busy=0 immediately; no done pulse afterwards. A new mult after release completes normally.
